// File: rtl/nco_multi_pkg.sv
// Shared definitions for the multi-channel NCO: output full-scale helper,
// quarter-wave table generator, quadrant encoding, pipeline latency and
// the dither LFSR constants (used only when NCO_DITHER_EN is defined).
package nco_multi_pkg;

    localparam int NCO_LAT = 4;

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form: feedback is the XOR of bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam real PI = 3.14159265358979323846;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_t;

    // Largest positive sample; the negative rail is kept symmetric at -full_scale.
    function automatic int full_scale(input int swidth);
        return (1 << (swidth - 1)) - 1;
    endfunction

    // Quarter-wave table entry k of 2^awidth, rounded to nearest (values are never negative).
    function automatic int lut_entry(input int k, input int awidth, input int swidth);
        real x;
        x = real'(full_scale(swidth)) * $sin(PI / 2.0 * real'(k) / real'(1 << awidth));
        return $rtoi(x + 0.5);
    endfunction

endpackage

// File: rtl/nco_quarter_lut.sv
// Quarter-wave sine magnitude ROM with two registered read ports.
// Addresses span 0..N inclusive; address N is the quadrant peak, which the
// N-entry table does not hold, so it is substituted with full scale here.
module nco_quarter_lut
    import nco_multi_pkg::*;
#(
    parameter int LUT_AWIDTH = 10,
    parameter int SWIDTH     = 18
)(
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_enable,
    input  logic [LUT_AWIDTH:0]   i_addr_sin,
    input  logic [LUT_AWIDTH:0]   i_addr_cos,
    output logic [SWIDTH-2:0]     o_mag_sin,
    output logic [SWIDTH-2:0]     o_mag_cos
);

    localparam int                N    = 1 << LUT_AWIDTH;
    localparam logic [SWIDTH-2:0] FULL = (SWIDTH-1)'(full_scale(SWIDTH));

    logic [SWIDTH-2:0] rom [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rom
            assign rom[gi] = (SWIDTH-1)'(lut_entry(gi, LUT_AWIDTH, SWIDTH));
        end
    endgenerate

    // Registered read of both ports, with the peak address mapped to full scale.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_mag_sin <= '0;
            o_mag_cos <= '0;
        end else if (i_enable) begin
            o_mag_sin <= i_addr_sin[LUT_AWIDTH] ? FULL : rom[i_addr_sin[LUT_AWIDTH-1:0]];
            o_mag_cos <= i_addr_cos[LUT_AWIDTH] ? FULL : rom[i_addr_cos[LUT_AWIDTH-1:0]];
        end
    end

endmodule

// File: rtl/nco_multi.sv
// Time-multiplexed multi-channel NCO producing quadrature sine/cosine.
// Pipeline (4 enabled cycles): phase -> quadrant fold -> ROM read -> sign.
// Optional macro NCO_DITHER_EN adds LFSR phase dither ahead of truncation.
module nco_multi
    import nco_multi_pkg::*;
#(
    parameter int NCHAN      = 4,
    parameter int FWIDTH     = 32,
    parameter int LUT_AWIDTH = 10,
    parameter int SWIDTH     = 18,
    parameter int CWIDTH     = (NCHAN > 1) ? $clog2(NCHAN) : 1
)(
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic                     i_enable,
    input  logic                     i_valid,
    input  logic [CWIDTH-1:0]        i_chan,
    input  logic                     i_cfg_wr,
    input  logic [CWIDTH-1:0]        i_cfg_chan,
    input  logic [FWIDTH-1:0]        i_cfg_freq,
    input  logic [FWIDTH-1:0]        i_cfg_offset,
    input  logic                     i_cfg_clr,
    output logic                     o_valid,
    output logic [CWIDTH-1:0]        o_chan,
    output logic signed [SWIDTH-1:0] o_sine,
    output logic signed [SWIDTH-1:0] o_cosine
);

    localparam int                  TW     = LUT_AWIDTH + 2;
    localparam logic [LUT_AWIDTH:0] N_ADDR = (LUT_AWIDTH+1)'(1 << LUT_AWIDTH);

    logic smp_hit;
    assign smp_hit = i_valid && ({1'b0, i_chan} < (CWIDTH+1)'(NCHAN));

    logic [FWIDTH-1:0] acc_vec [NCHAN];
    logic [FWIDTH-1:0] off_vec [NCHAN];

    genvar gi;
    generate
        for (gi = 0; gi < NCHAN; gi++) begin : g_chan
            logic [FWIDTH-1:0] acc_reg;
            logic [FWIDTH-1:0] freq_reg;
            logic [FWIDTH-1:0] off_reg;
            logic              smp_sel;
            logic              cfg_sel;

            assign smp_sel = smp_hit && (i_chan == CWIDTH'(gi));
            assign cfg_sel = i_cfg_wr && (i_cfg_chan == CWIDTH'(gi));

            // Per-channel state: config load, and accumulator advance where a clear overrides the step.
            always_ff @(posedge i_clock or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    acc_reg  <= '0;
                    freq_reg <= '0;
                    off_reg  <= '0;
                end else if (i_enable) begin
                    if (cfg_sel) begin
                        freq_reg <= i_cfg_freq;
                        off_reg  <= i_cfg_offset;
                    end
                    if (cfg_sel && i_cfg_clr) begin
                        acc_reg <= '0;
                    end else if (smp_sel) begin
                        acc_reg <= acc_reg + freq_reg;
                    end
                end
            end

            assign acc_vec[gi] = acc_reg;
            assign off_vec[gi] = off_reg;
        end
    endgenerate

`ifdef NCO_DITHER_EN
    localparam int                DW    = FWIDTH - LUT_AWIDTH - 2;
    localparam logic [FWIDTH-1:0] DMASK = (FWIDTH'(1) << DW) - FWIDTH'(1);

    logic [15:0]       lfsr_reg;
    logic [FWIDTH-1:0] dither;

    // Dither source steps on every enabled cycle, independent of sample traffic.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lfsr_reg <= LFSR_SEED;
        end else if (i_enable) begin
            lfsr_reg <= {lfsr_reg[14:0], ^(lfsr_reg & LFSR_TAPS)};
        end
    end

    assign dither = FWIDTH'(lfsr_reg) & DMASK;
`else
    logic [FWIDTH-1:0] dither;
    assign dither = '0;
`endif

    // Stage 0: channel phase, read before this cycle's accumulator update lands.
    logic [FWIDTH-1:0] phase_next;
    logic              unused_phase_lsbs;
    assign phase_next        = acc_vec[i_chan] + off_vec[i_chan] + dither;
    assign unused_phase_lsbs = ^phase_next[FWIDTH-TW-1:0];

    logic [TW-1:0]     ph_reg;
    logic              vld0_reg;
    logic [CWIDTH-1:0] chan0_reg;

    // Register the truncated phase together with the strobe and its channel tag.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ph_reg    <= '0;
            vld0_reg  <= 1'b0;
            chan0_reg <= '0;
        end else if (i_enable) begin
            ph_reg    <= phase_next[FWIDTH-1 -: TW];
            vld0_reg  <= smp_hit;
            chan0_reg <= i_chan;
        end
    end

    // Map a quadrant/offset pair to {negate, table address 0..N}.
    function automatic logic [LUT_AWIDTH+1:0] fold(input logic [1:0] q, input logic [LUT_AWIDTH-1:0] a);
        quadrant_t qd;
        qd = quadrant_t'(q);
        case (qd)
            Q0:      return {1'b0, 1'b0, a};
            Q1:      return {1'b0, N_ADDR - {1'b0, a}};
            Q2:      return {1'b1, 1'b0, a};
            default: return {1'b1, N_ADDR - {1'b0, a}};
        endcase
    endfunction

    logic [1:0]            q_sin;
    logic [1:0]            q_cos;
    logic [LUT_AWIDTH+1:0] fold_sin;
    logic [LUT_AWIDTH+1:0] fold_cos;

    assign q_sin    = ph_reg[TW-1 -: 2];
    assign q_cos    = q_sin + 2'd1;
    assign fold_sin = fold(q_sin, ph_reg[LUT_AWIDTH-1:0]);
    assign fold_cos = fold(q_cos, ph_reg[LUT_AWIDTH-1:0]);

    logic [LUT_AWIDTH:0] addr_sin_reg;
    logic [LUT_AWIDTH:0] addr_cos_reg;
    logic                neg_sin1_reg;
    logic                neg_cos1_reg;
    logic                vld1_reg;
    logic [CWIDTH-1:0]   chan1_reg;

    // Stage 1: fold both quadrature phases into table addresses and sign flags.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            addr_sin_reg <= '0;
            addr_cos_reg <= '0;
            neg_sin1_reg <= 1'b0;
            neg_cos1_reg <= 1'b0;
            vld1_reg     <= 1'b0;
            chan1_reg    <= '0;
        end else if (i_enable) begin
            addr_sin_reg <= fold_sin[LUT_AWIDTH:0];
            addr_cos_reg <= fold_cos[LUT_AWIDTH:0];
            neg_sin1_reg <= fold_sin[LUT_AWIDTH+1];
            neg_cos1_reg <= fold_cos[LUT_AWIDTH+1];
            vld1_reg     <= vld0_reg;
            chan1_reg    <= chan0_reg;
        end
    end

    // Stage 2: table read.
    logic [SWIDTH-2:0] lut_sin;
    logic [SWIDTH-2:0] lut_cos;

    nco_quarter_lut #(
        .LUT_AWIDTH (LUT_AWIDTH),
        .SWIDTH     (SWIDTH)
    ) u_lut (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_enable   (i_enable),
        .i_addr_sin (addr_sin_reg),
        .i_addr_cos (addr_cos_reg),
        .o_mag_sin  (lut_sin),
        .o_mag_cos  (lut_cos)
    );

    logic              neg_sin2_reg;
    logic              neg_cos2_reg;
    logic              vld2_reg;
    logic [CWIDTH-1:0] chan2_reg;

    // Carry sign flags and tags alongside the table read.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            neg_sin2_reg <= 1'b0;
            neg_cos2_reg <= 1'b0;
            vld2_reg     <= 1'b0;
            chan2_reg    <= '0;
        end else if (i_enable) begin
            neg_sin2_reg <= neg_sin1_reg;
            neg_cos2_reg <= neg_cos1_reg;
            vld2_reg     <= vld1_reg;
            chan2_reg    <= chan1_reg;
        end
    end

    logic signed [SWIDTH-1:0] mag_sin;
    logic signed [SWIDTH-1:0] mag_cos;
    assign mag_sin = $signed({1'b0, lut_sin});
    assign mag_cos = $signed({1'b0, lut_cos});

    // Stage 3: apply sign; magnitudes never exceed full scale so the range stays symmetric.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid  <= 1'b0;
            o_chan   <= '0;
            o_sine   <= '0;
            o_cosine <= '0;
        end else if (i_enable) begin
            o_valid  <= vld2_reg;
            o_chan   <= chan2_reg;
            o_sine   <= neg_sin2_reg ? -mag_sin : mag_sin;
            o_cosine <= neg_cos2_reg ? -mag_cos : mag_cos;
        end
    end

endmodule

// File: tb/tb_nco_multi.sv
// Self-checking bench for nco_multi: a phase-level model (ideal sin/cos of
// the truncated phase) feeds a scoreboard checked every enabled cycle,
// plus literal expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_nco_multi;

    localparam int NCHAN = 4;
    localparam int FW    = 32;
    localparam int LA    = 10;
    localparam int SW    = 18;
    localparam int CW    = 2;
    localparam int FULL  = 131071;
    localparam int LAT   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          valid = 1'b0;
    logic [CW-1:0] chan = '0;
    logic          cfg_wr = 1'b0;
    logic [CW-1:0] cfg_chan = '0;
    logic [FW-1:0] cfg_freq = '0;
    logic [FW-1:0] cfg_offset = '0;
    logic          cfg_clr = 1'b0;

    logic                 o_valid;
    logic [CW-1:0]        o_chan;
    logic signed [SW-1:0] o_sine;
    logic signed [SW-1:0] o_cosine;

    always #5 clk = ~clk;

    nco_multi #(
        .NCHAN      (NCHAN),
        .FWIDTH     (FW),
        .LUT_AWIDTH (LA),
        .SWIDTH     (SW)
    ) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_enable     (en),
        .i_valid      (valid),
        .i_chan       (chan),
        .i_cfg_wr     (cfg_wr),
        .i_cfg_chan   (cfg_chan),
        .i_cfg_freq   (cfg_freq),
        .i_cfg_offset (cfg_offset),
        .i_cfg_clr    (cfg_clr),
        .o_valid      (o_valid),
        .o_chan       (o_chan),
        .o_sine       (o_sine),
        .o_cosine     (o_cosine)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Ideal quadrature value of the 12-bit truncated phase, rounded half away from zero.
    function automatic int wave(input logic [FW-1:0] p, input bit cosine);
        logic [11:0] t;
        real ang;
        real v;
        t   = p[FW-1 -: 12];
        ang = 2.0 * 3.14159265358979323846 * real'(t) / 4096.0;
        v   = real'(FULL) * (cosine ? $cos(ang) : $sin(ang));
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    typedef struct { int ch; int s; int c; int due; } exp_t;
    typedef struct { int ch; int s; int c; } out_t;

    exp_t          expq[$];
    out_t          got[$];
    exp_t          m_e;
    out_t          m_o;
    logic [FW-1:0] m_acc [NCHAN];
    logic [FW-1:0] m_freq [NCHAN];
    logic [FW-1:0] m_off [NCHAN];
    logic [FW-1:0] m_p;
    logic [15:0]   m_lfsr;
    int            ecnt = 0;
    bit            en_last = 1'b0;

    // Model: apply the channel rules on every clock edge the DUT would see.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCHAN; k++) begin
                m_acc[k]  = '0;
                m_freq[k] = '0;
                m_off[k]  = '0;
            end
            expq.delete();
            ecnt    = 0;
            en_last = 1'b0;
            m_lfsr  = 16'hACE1;
        end else begin
            en_last = en;
            if (en) begin
                if (valid && int'(chan) < NCHAN) begin
                    m_p = m_acc[chan] + m_off[chan];
`ifdef NCO_DITHER_EN
                    m_p = m_p + {16'h0, m_lfsr};
`endif
                    m_e.ch  = int'(chan);
                    m_e.s   = wave(m_p, 1'b0);
                    m_e.c   = wave(m_p, 1'b1);
                    m_e.due = ecnt + LAT;
                    expq.push_back(m_e);
                    m_acc[chan] = m_acc[chan] + m_freq[chan];
                end
                if (cfg_wr && int'(cfg_chan) < NCHAN) begin
                    m_freq[cfg_chan] = cfg_freq;
                    m_off[cfg_chan]  = cfg_offset;
                    if (cfg_clr) m_acc[cfg_chan] = '0;
                end
`ifdef NCO_DITHER_EN
                m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
                ecnt++;
            end
        end
    end

    logic                 prev_v = 1'b0;
    logic [CW-1:0]        prev_ch = '0;
    logic signed [SW-1:0] prev_s = '0;
    logic signed [SW-1:0] prev_c = '0;

    // Compare: mid-cycle, check reset values, freezing, and each consumed output.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_valid", o_valid, 0);
            check("reset_sine", o_sine, 0);
            check("reset_cosine", o_cosine, 0);
        end else begin
            if (!en_last) begin
                check("freeze_valid", o_valid, prev_v);
                check("freeze_chan", o_chan, prev_ch);
                check("freeze_sine", o_sine, prev_s);
                check("freeze_cosine", o_cosine, prev_c);
            end
            if (en) begin
                if (o_valid) begin
                    if (expq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_output: got o_valid=1 chan %0d, expected no output", o_chan);
                    end else begin
                        m_e = expq.pop_front();
                        check("out_chan", o_chan, m_e.ch);
                        check("out_sine", o_sine, m_e.s);
                        check("out_cosine", o_cosine, m_e.c);
                        check("out_latency", ecnt, m_e.due);
                        m_o.ch = int'(o_chan);
                        m_o.s  = int'(o_sine);
                        m_o.c  = int'(o_cosine);
                        got.push_back(m_o);
                        $display("[TB] out chan %0d sine %0d cosine %0d", o_chan, o_sine, o_cosine);
                    end
                end else if (expq.size() > 0 && expq[0].due <= ecnt) begin
                    tests++;
                    fails++;
                    $display("FAIL missing_output: got o_valid=0, expected output for chan %0d", expq[0].ch);
                    void'(expq.pop_front());
                end
            end
        end
        prev_v  = o_valid;
        prev_ch = o_chan;
        prev_s  = o_sine;
        prev_c  = o_cosine;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic cfg(input int ch, input logic [FW-1:0] f, input logic [FW-1:0] o, input bit clr);
        cfg_wr     = 1'b1;
        cfg_chan   = CW'(ch);
        cfg_freq   = f;
        cfg_offset = o;
        cfg_clr    = clr;
        cycle();
        cfg_wr  = 1'b0;
        cfg_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int sp [4];
    int cp [4];

    initial begin
        sp[0] = 0;    sp[1] = FULL; sp[2] = 0;     sp[3] = -FULL;
        cp[0] = FULL; cp[1] = 0;    cp[2] = -FULL; cp[3] = 0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        en    = 1'b1;

        // 1: idle, no output
        idle(100);
        check("idle_count", got.size(), 0);

        // 2: ch0 quarter-turn steps
        cfg(0, 32'h4000_0000, 32'h0, 1'b0);
        got.delete();
        valid = 1'b1;
        chan  = 2'd0;
        idle(8);
        valid = 1'b0;
        idle(8);
        check("t2_count", got.size(), 8);
        for (int k = 0; k < got.size(); k++) begin
            check("t2_sine", got[k].s, sp[k % 4]);
            check("t2_cosine", got[k].c, cp[k % 4]);
        end

        // 3: ch1 half-turn steps interleaved with static ch2
        cfg(1, 32'h8000_0000, 32'h0, 1'b0);
        cfg(2, 32'h0, 32'h4000_0000, 1'b0);
        got.delete();
        valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chan = (i % 2 == 1) ? 2'd2 : 2'd1;
            cycle();
        end
        valid = 1'b0;
        idle(8);
        check("t3_count", got.size(), 12);
        for (int k = 0; k < got.size(); k++) begin
            check("t3_chan", got[k].ch, (k % 2 == 1) ? 2 : 1);
            if (k % 2 == 0) begin
                check("t3_ch1_sine", got[k].s, 0);
                check("t3_ch1_cosine", got[k].c, ((k / 2) % 2 == 0) ? FULL : -FULL);
            end else begin
                check("t3_ch2_sine", got[k].s, FULL);
                check("t3_ch2_cosine", got[k].c, 0);
            end
        end

        // 4: continuous ch0 with a 5-cycle enable gap
        got.delete();
        valid = 1'b1;
        chan  = 2'd0;
        for (int i = 0; i < 25; i++) begin
            en = !(i >= 10 && i < 15);
            cycle();
        end
        en    = 1'b1;
        valid = 1'b0;
        idle(8);
        check("t4_count", got.size(), 20);
        for (int k = 0; k < got.size(); k++) begin
            check("t4_sine", got[k].s, sp[k % 4]);
            check("t4_cosine", got[k].c, cp[k % 4]);
        end

        // 5: clear + new offset in the same cycle as a ch0 sample at phase 3/4
        got.delete();
        valid = 1'b1;
        chan  = 2'd0;
        idle(3);
        cfg_wr     = 1'b1;
        cfg_chan   = 2'd0;
        cfg_freq   = 32'h4000_0000;
        cfg_offset = 32'h4000_0000;
        cfg_clr    = 1'b1;
        cycle();
        cfg_wr  = 1'b0;
        cfg_clr = 1'b0;
        cycle();
        valid = 1'b0;
        idle(8);
        check("t5_count", got.size(), 5);
        if (got.size() == 5) begin
            check("t5_clr_sample_sine", got[3].s, -FULL);
            check("t5_clr_sample_cosine", got[3].c, 0);
            check("t5_next_sine", got[4].s, FULL);
            check("t5_next_cosine", got[4].c, 0);
        end

        // 6: asynchronous reset mid-stream
        valid = 1'b1;
        chan  = 2'd0;
        idle(6);
        check("t6_pre_reset_valid", o_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", o_valid, 0);
        check("t6_async_chan", o_chan, 0);
        check("t6_async_sine", o_sine, 0);
        check("t6_async_cosine", o_cosine, 0);
        valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();
        idle(10);
        check("t6_no_stale", got.size(), 0);
        valid = 1'b1;
        chan  = 2'd0;
        cycle();
        valid = 1'b0;
        idle(8);
        check("t6_count", got.size(), 1);
        if (got.size() == 1) begin
            check("t6_first_sine", got[0].s, 0);
            check("t6_first_cosine", got[0].c, FULL);
        end

        check("queue_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
